// File: rtl/dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dispatch_pkg                                                      |
// | Purpose: Shared constants, queue-entry type and opcode helper for the      |
// |          dispatcher and its operand resolver.                              |
// | Contents: entry field widths, opcode encodings (NOP, LB..SW load/store     |
// |           range, a few ALU ops), TAG_NONE, dq_entry_t, is_mem_op().        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package dispatch_pkg;

   // Field widths of a queued decoded instruction.
   localparam int DQ_OPENUM_W = 6;
   localparam int DQ_REG_W    = 5;
   localparam int DQ_DATA_W   = 32;
   localparam int DQ_ADDR_W   = 32;

   // Opcode encodings. All loads and stores sit contiguously in LB..SW.
   localparam logic [DQ_OPENUM_W-1:0] OPENUM_NOP  = 6'd0;
   localparam logic [DQ_OPENUM_W-1:0] OPENUM_LB   = 6'd11;
   localparam logic [DQ_OPENUM_W-1:0] OPENUM_SW   = 6'd18;
   localparam logic [DQ_OPENUM_W-1:0] OPENUM_ADDI = 6'd19;
   localparam logic [DQ_OPENUM_W-1:0] OPENUM_ADD  = 6'd28;

   // Tag value meaning "operand has no outstanding producer".
   localparam int TAG_NONE = 0;

   typedef struct packed {
      logic [DQ_OPENUM_W-1:0] openum;
      logic [DQ_REG_W-1:0]    rd;
      logic [DQ_REG_W-1:0]    rs1;
      logic [DQ_REG_W-1:0]    rs2;
      logic [DQ_DATA_W-1:0]   imm;
      logic [DQ_ADDR_W-1:0]   pc;
   } dq_entry_t;

   // Loads/stores go to the LSB; everything else goes to the RS.
   function automatic logic is_mem_op(input logic [DQ_OPENUM_W-1:0] op);
      return (op >= OPENUM_LB) && (op <= OPENUM_SW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : operand_resolver                                                  |
// | Purpose: Resolve one source operand. Priority: regfile value when the      |
// |          regfile tag is empty; else a matching CDB broadcast (lowest       |
// |          channel wins); else a ROB entry that already holds its result;    |
// |          else the operand stays pending with value 0 and its tag kept.     |
// | Ports  : q_reg_i/v_reg_i     regfile tag/value                            |
// |          cdb_valid_i/cdb_rob_id_i/cdb_value_i  flattened broadcast bus     |
// |          rob_ready_i/v_rob_i  ROB lookup for q_reg_i                       |
// |          v_o/q_o              resolved value and remaining tag             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module operand_resolver
   import dispatch_pkg::*;
#(
   parameter int NUM_CDB  = 2,
   parameter int ROB_LEN  = 4,
   parameter int DATA_LEN = 32
) (
   input  logic [ROB_LEN:0]              q_reg_i,
   input  logic [DATA_LEN-1:0]           v_reg_i,
   input  logic [NUM_CDB-1:0]            cdb_valid_i,
   input  logic [NUM_CDB*(ROB_LEN+1)-1:0] cdb_rob_id_i,
   input  logic [NUM_CDB*DATA_LEN-1:0]   cdb_value_i,
   input  logic                          rob_ready_i,
   input  logic [DATA_LEN-1:0]           v_rob_i,
   output logic [DATA_LEN-1:0]           v_o,
   output logic [ROB_LEN:0]              q_o
);

   localparam int TAG_W = ROB_LEN + 1;

   logic                w_cdb_hit;
   logic [DATA_LEN-1:0] w_cdb_val;

   // Scan from the highest channel down so the lowest matching channel is
   // the last one written and therefore wins.
   always_comb begin
      w_cdb_hit = 1'b0;
      w_cdb_val = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
         if (cdb_valid_i[i] && (cdb_rob_id_i[i*TAG_W +: TAG_W] == q_reg_i)) begin
            w_cdb_hit = 1'b1;
            w_cdb_val = cdb_value_i[i*DATA_LEN +: DATA_LEN];
         end
      end
   end

   always_comb begin
      v_o = '0;
      q_o = q_reg_i;
      if (q_reg_i == TAG_W'(TAG_NONE)) begin
         v_o = v_reg_i;
         q_o = '0;
      end else if (w_cdb_hit) begin
         v_o = w_cdb_val;
         q_o = '0;
      end else if (rob_ready_i) begin
         v_o = v_rob_i;
         q_o = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dispatch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dispatch_queue                                                    |
// | Purpose: Decoded-instruction queue feeding RS/LSB. The head is resolved    |
// |          against regfile, CDB and ROB, allocated a ROB tag, its rd is      |
// |          renamed, and it is issued with registered 1-cycle pulses.         |
// | Ports  : clk/rst/rdy/flush       control                                  |
// |          in_*                     decoder handshake and fields            |
// |          *_rob / rob_*            ROB allocation and ready lookup         |
// |          *_reg                    regfile query and rename                |
// |          cdb_*                    flattened result broadcast              |
// |          *_rs / *_lsb             station full flags and issue payload    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int IQ_DEPTH   = 4,
   parameter int NUM_CDB    = 2,
   parameter int ROB_LEN    = 4,
   parameter int DATA_LEN   = DQ_DATA_W,
   parameter int ADDR_LEN   = DQ_ADDR_W,
   parameter int REG_LEN    = DQ_REG_W,
   parameter int OPENUM_LEN = DQ_OPENUM_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [OPENUM_LEN-1:0]          in_openum,
   input  logic [REG_LEN-1:0]             in_rd,
   input  logic [REG_LEN-1:0]             in_rs1,
   input  logic [REG_LEN-1:0]             in_rs2,
   input  logic [DATA_LEN-1:0]            in_imm,
   input  logic [ADDR_LEN-1:0]            in_pc,
   input  logic                           rob_full,
   input  logic [ROB_LEN:0]               rob_id_from_rob,
   output logic                           ena_to_rob,
   output logic [REG_LEN-1:0]             rd_to_rob,
   output logic [ADDR_LEN-1:0]            pc_to_rob,
   output logic [REG_LEN-1:0]             rs1_to_reg,
   output logic [REG_LEN-1:0]             rs2_to_reg,
   input  logic [DATA_LEN-1:0]            V1_from_reg,
   input  logic [DATA_LEN-1:0]            V2_from_reg,
   input  logic [ROB_LEN:0]               Q1_from_reg,
   input  logic [ROB_LEN:0]               Q2_from_reg,
   output logic [ROB_LEN:0]               Q1_to_rob,
   output logic [ROB_LEN:0]               Q2_to_rob,
   input  logic                           Q1_ready_from_rob,
   input  logic                           Q2_ready_from_rob,
   input  logic [DATA_LEN-1:0]            V1_from_rob,
   input  logic [DATA_LEN-1:0]            V2_from_rob,
   input  logic [NUM_CDB-1:0]             cdb_valid,
   input  logic [NUM_CDB*(ROB_LEN+1)-1:0] cdb_rob_id,
   input  logic [NUM_CDB*DATA_LEN-1:0]    cdb_value,
   output logic                           ena_to_reg,
   output logic [REG_LEN-1:0]             rd_to_reg,
   output logic [ROB_LEN:0]               Q_to_reg,
   input  logic                           rs_full,
   input  logic                           lsb_full,
   output logic                           ena_to_rs,
   output logic [OPENUM_LEN-1:0]          openum_to_rs,
   output logic [DATA_LEN-1:0]            V1_to_rs,
   output logic [DATA_LEN-1:0]            V2_to_rs,
   output logic [ROB_LEN:0]               Q1_to_rs,
   output logic [ROB_LEN:0]               Q2_to_rs,
   output logic [ADDR_LEN-1:0]            pc_to_rs,
   output logic [DATA_LEN-1:0]            imm_to_rs,
   output logic [ROB_LEN:0]               rob_id_to_rs,
   output logic                           ena_to_lsb,
   output logic [OPENUM_LEN-1:0]          openum_to_lsb,
   output logic [DATA_LEN-1:0]            V1_to_lsb,
   output logic [DATA_LEN-1:0]            V2_to_lsb,
   output logic [ROB_LEN:0]               Q1_to_lsb,
   output logic [ROB_LEN:0]               Q2_to_lsb,
   output logic [DATA_LEN-1:0]            imm_to_lsb,
   output logic [ROB_LEN:0]               rob_id_to_lsb
);

   localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int CNT_W = $clog2(IQ_DEPTH) + 1;
   localparam int TAG_W = ROB_LEN + 1;

   dq_entry_t        queue_q [IQ_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   dq_entry_t           w_head;
   dq_entry_t           w_in_entry;
   logic                w_head_valid;
   logic                w_is_mem;
   logic                w_push;
   logic                w_pop;
   logic [DATA_LEN-1:0] w_v1, w_v2;
   logic [TAG_W-1:0]    w_q1, w_q2;

   assign w_head       = queue_q[head_q];
   assign w_head_valid = (count_q != '0);
   assign w_is_mem     = is_mem_op(w_head.openum);
   assign in_ready     = (count_q != CNT_W'(IQ_DEPTH));

   // A NOP completes the handshake but is never stored.
   assign w_push = in_valid & in_ready & rdy & ~flush
                 & (in_openum != OPENUM_LEN'(OPENUM_NOP));

   // Flush also blocks dispatch, so flush wins over an eligible head.
   assign w_pop = w_head_valid & ~rob_full & rdy & ~flush
                & (w_is_mem ? ~lsb_full : ~rs_full);

   assign w_in_entry.openum = in_openum;
   assign w_in_entry.rd     = in_rd;
   assign w_in_entry.rs1    = in_rs1;
   assign w_in_entry.rs2    = in_rs2;
   assign w_in_entry.imm    = in_imm;
   assign w_in_entry.pc     = in_pc;

   // Regfile and ROB lookups are combinational from the current head.
   assign rs1_to_reg = w_head.rs1;
   assign rs2_to_reg = w_head.rs2;
   assign Q1_to_rob  = Q1_from_reg;
   assign Q2_to_rob  = Q2_from_reg;

   operand_resolver #(
      .NUM_CDB  (NUM_CDB),
      .ROB_LEN  (ROB_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_res_rs1 (
      .q_reg_i      (Q1_from_reg),
      .v_reg_i      (V1_from_reg),
      .cdb_valid_i  (cdb_valid),
      .cdb_rob_id_i (cdb_rob_id),
      .cdb_value_i  (cdb_value),
      .rob_ready_i  (Q1_ready_from_rob),
      .v_rob_i      (V1_from_rob),
      .v_o          (w_v1),
      .q_o          (w_q1)
   );

   operand_resolver #(
      .NUM_CDB  (NUM_CDB),
      .ROB_LEN  (ROB_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_res_rs2 (
      .q_reg_i      (Q2_from_reg),
      .v_reg_i      (V2_from_reg),
      .cdb_valid_i  (cdb_valid),
      .cdb_rob_id_i (cdb_rob_id),
      .cdb_value_i  (cdb_value),
      .rob_ready_i  (Q2_ready_from_rob),
      .v_rob_i      (V2_from_rob),
      .v_o          (w_v2),
      .q_o          (w_q2)
   );

   // Pointer/count next state. rdy=0 freezes everything, flush included.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy && flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) tail_d = tail_q + PTR_W'(1);
         if (w_pop)  head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset: validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (w_push) queue_q[tail_q] <= w_in_entry;
   end

   // Issue registers. Enables default low every enabled or frozen edge, so a
   // pulse never repeats; payload holds its last value between dispatches.
   always_ff @(posedge clk) begin
      if (rst) begin
         ena_to_rob    <= 1'b0;
         rd_to_rob     <= '0;
         pc_to_rob     <= '0;
         ena_to_reg    <= 1'b0;
         rd_to_reg     <= '0;
         Q_to_reg      <= '0;
         ena_to_rs     <= 1'b0;
         openum_to_rs  <= '0;
         V1_to_rs      <= '0;
         V2_to_rs      <= '0;
         Q1_to_rs      <= '0;
         Q2_to_rs      <= '0;
         pc_to_rs      <= '0;
         imm_to_rs     <= '0;
         rob_id_to_rs  <= '0;
         ena_to_lsb    <= 1'b0;
         openum_to_lsb <= '0;
         V1_to_lsb     <= '0;
         V2_to_lsb     <= '0;
         Q1_to_lsb     <= '0;
         Q2_to_lsb     <= '0;
         imm_to_lsb    <= '0;
         rob_id_to_lsb <= '0;
      end else begin
         ena_to_rob <= 1'b0;
         ena_to_reg <= 1'b0;
         ena_to_rs  <= 1'b0;
         ena_to_lsb <= 1'b0;
         if (w_pop) begin
            ena_to_rob <= 1'b1;
            rd_to_rob  <= w_head.rd;
            pc_to_rob  <= w_head.pc;
            // x0 is never renamed.
            if (w_head.rd != '0) begin
               ena_to_reg <= 1'b1;
               rd_to_reg  <= w_head.rd;
               Q_to_reg   <= rob_id_from_rob;
            end
            if (w_is_mem) begin
               ena_to_lsb    <= 1'b1;
               openum_to_lsb <= w_head.openum;
               V1_to_lsb     <= w_v1;
               V2_to_lsb     <= w_v2;
               Q1_to_lsb     <= w_q1;
               Q2_to_lsb     <= w_q2;
               imm_to_lsb    <= w_head.imm;
               rob_id_to_lsb <= rob_id_from_rob;
            end else begin
               ena_to_rs    <= 1'b1;
               openum_to_rs <= w_head.openum;
               V1_to_rs     <= w_v1;
               V2_to_rs     <= w_v2;
               Q1_to_rs     <= w_q1;
               Q2_to_rs     <= w_q2;
               pc_to_rs     <= w_head.pc;
               imm_to_rs    <= w_head.imm;
               rob_id_to_rs <= rob_id_from_rob;
            end
         end
      end
   end

endmodule
`default_nettype wire
